// File: rtl/pdpu_chunk_sequencer.sv
// Issue/recirculate sequencer for a combinational PDPU: streams N-lane operand beats,
// folds each partial result back into the accumulator and emits one result per vector.
module pdpu_chunk_sequencer #(
    parameter int N         = 4,
    parameter int n_i       = 8,
    parameter int n_o       = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,

    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [N*n_i-1:0]     in_operands_a_i,
    input  logic [N*n_i-1:0]     in_operands_b_i,
    input  logic                 in_last_i,
    input  logic [n_o-1:0]       acc_init_i,

    output logic [N*n_i-1:0]     pdpu_operands_a_o,
    output logic [N*n_i-1:0]     pdpu_operands_b_o,
    output logic [n_o-1:0]       pdpu_acc_o,
    input  logic [n_o-1:0]       pdpu_result_i,

    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [n_o-1:0]       out_result_o,
    output logic [CNT_WIDTH-1:0] out_beats_o
);

    logic [N*n_i-1:0]     op_a_q;
    logic [N*n_i-1:0]     op_b_q;
    logic                 op_valid_q;
    logic                 op_last_q;
    logic                 first_q;
    logic [n_o-1:0]       acc_q;
    logic [CNT_WIDTH-1:0] beat_cnt_q;
    logic                 out_valid_q;
    logic [n_o-1:0]       out_result_q;
    logic [CNT_WIDTH-1:0] out_beats_q;

    logic stall;
    logic accept;
    logic op_step;
    logic op_finish;

    // Only a finished vector waiting on a full, unread output register blocks the pipe.
    assign stall     = op_valid_q & op_last_q & out_valid_q & ~out_ready_i;
    assign in_ready_o = ~stall & ~rst_i & ~flush_i;
    assign accept    = in_valid_i & in_ready_o;
    assign op_step   = op_valid_q & ~op_last_q & ~stall;
    assign op_finish = op_valid_q & op_last_q & ~stall & ~flush_i;

    assign pdpu_operands_a_o = op_a_q;
    assign pdpu_operands_b_o = op_b_q;
    assign pdpu_acc_o        = acc_q;
    assign out_valid_o       = out_valid_q;
    assign out_result_o      = out_result_q;
    assign out_beats_o       = out_beats_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            op_last_q  <= 1'b0;
        end else if (flush_i) begin
            op_valid_q <= 1'b0;
        end else if (accept) begin
            op_a_q     <= in_operands_a_i;
            op_b_q     <= in_operands_b_i;
            op_valid_q <= 1'b1;
            op_last_q  <= in_last_i;
        end else if (!stall) begin
            op_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            first_q    <= 1'b1;
            beat_cnt_q <= '0;
        end else if (flush_i) begin
            first_q    <= 1'b1;
            beat_cnt_q <= '0;
        end else if (accept) begin
            first_q <= in_last_i;
            if (first_q) begin
                beat_cnt_q <= CNT_WIDTH'(1);
            end else if (beat_cnt_q != '1) begin
                beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // A first beat is only accepted when the op stage is empty or holds a last beat,
    // so the two writers below never collide.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else if (accept && first_q) begin
            acc_q <= acc_init_i;
        end else if (op_step) begin
            acc_q <= pdpu_result_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_beats_q  <= '0;
        end else if (op_finish) begin
            out_valid_q  <= 1'b1;
            out_result_q <= pdpu_result_i;
            out_beats_q  <= beat_cnt_q;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdpu_chunk_sequencer.sv
// Scoreboard bench for pdpu_chunk_sequencer with an integer multiply-accumulate stand-in PDPU.
module tb_pdpu_chunk_sequencer;

    localparam int N  = 4;
    localparam int NI = 8;
    localparam int NO = 16;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*NI-1:0] in_a = '0;
    logic [N*NI-1:0] in_b = '0;
    logic            in_last = 1'b0;
    logic [NO-1:0]   acc_init = '0;
    logic [N*NI-1:0] pdpu_a;
    logic [N*NI-1:0] pdpu_b;
    logic [NO-1:0]   pdpu_acc;
    logic [NO-1:0]   pdpu_result;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [NO-1:0]   out_result;
    logic [CW-1:0]   out_beats;

    int total = 0;
    int bad   = 0;

    logic [NO-1:0] exp_res_q[$];
    int            exp_beats_q[$];

    bit ready_rand  = 1'b0;
    bit ready_fixed = 1'b1;

    pdpu_chunk_sequencer #(
        .N(N),
        .n_i(NI),
        .n_o(NO),
        .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .flush_i(flush),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .in_operands_a_i(in_a),
        .in_operands_b_i(in_b),
        .in_last_i(in_last),
        .acc_init_i(acc_init),
        .pdpu_operands_a_o(pdpu_a),
        .pdpu_operands_b_o(pdpu_b),
        .pdpu_acc_o(pdpu_acc),
        .pdpu_result_i(pdpu_result),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_result_o(out_result),
        .out_beats_o(out_beats)
    );

    initial forever #5 clk = ~clk;

    // Stand-in PDPU: wrap-around integer acc + sum(a*b); the sequencer only moves words.
    always_comb begin
        pdpu_result = pdpu_acc;
        for (int i = 0; i < N; i++) begin
            pdpu_result = pdpu_result + NO'(pdpu_a[i*NI +: NI]) * NO'(pdpu_b[i*NI +: NI]);
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_fixed;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Whole-vector reference: init plus the full dot product over every beat, mod 2^NO.
    function automatic logic [NO-1:0] ref_dot(input logic [NO-1:0] init,
                                              input logic [N*NI-1:0] av[$],
                                              input logic [N*NI-1:0] bv[$]);
        int s;
        logic [N*NI-1:0] wa;
        logic [N*NI-1:0] wb;
        s = int'(init);
        for (int k = 0; k < av.size(); k++) begin
            wa = av[k];
            wb = bv[k];
            for (int l = 0; l < N; l++) begin
                s = s + int'(wa[l*NI +: NI]) * int'(wb[l*NI +: NI]);
            end
        end
        return NO'(s);
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_res_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output actual=%0h required=none", out_result);
            end else begin
                check("result", out_result, exp_res_q.pop_front());
                check("beats", out_beats, exp_beats_q.pop_front());
            end
        end
    end

    task automatic send_beat(input logic [N*NI-1:0] a, input logic [N*NI-1:0] b,
                             input logic last, input logic [NO-1:0] init, output int stalls);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        acc_init = init;
        stalls   = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            stalls++;
        end
        total++;
        bad++;
        $display("FAIL accept_timeout actual=no_accept required=accept");
        in_valid = 1'b0;
    endtask

    task automatic run_vector(input int nbeats, input bit pat, input logic [NO-1:0] init,
                              input bit push, input int gap_max, input bit hold,
                              output int stalls);
        logic [N*NI-1:0] av[$];
        logic [N*NI-1:0] bv[$];
        int st;
        stalls = 0;
        for (int k = 0; k < nbeats; k++) begin
            av.push_back(pat ? {N{8'h40}} : N*NI'($urandom));
            bv.push_back(pat ? {N{8'h40}} : N*NI'($urandom));
        end
        if (push) begin
            exp_res_q.push_back(ref_dot(init, av, bv));
            exp_beats_q.push_back(nbeats);
        end
        for (int k = 0; k < nbeats; k++) begin
            if (gap_max > 0) begin
                int g;
                g = $urandom_range(0, gap_max);
                if (g > 0) begin
                    in_valid = 1'b0;
                    repeat (g) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            send_beat(av[k], bv[k], k == nbeats - 1, init, st);
            stalls += st;
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 500; t++) begin
            if (exp_res_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", exp_res_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int tot_st;
        logic [N*NI-1:0] cap_a;
        logic [NO-1:0]   cap_acc;

        // Reset state, with in_valid high to show ready is held low.
        in_valid = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_beats", out_beats, 0);
        check("rst_pdpu_a", pdpu_a, 0);
        check("rst_pdpu_acc", pdpu_acc, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 2-beat vector of 0x40 lanes, acc_init 0; result lands one cycle after last accept.
        run_vector(2, 1'b1, 16'h0000, 1'b1, 0, 1'b0, st);
        @(negedge clk);
        check("t1_not_early", out_valid, 0);
        @(negedge clk);
        check("t1_latency", out_valid, 1);
        drain();

        // Back-to-back 1-beat vectors with out_ready high: never a ready bubble.
        tot_st = 0;
        for (int i = 0; i < 4; i++) begin
            run_vector(1, 1'b1, (i % 2 == 0) ? 16'h4000 : 16'h0000, 1'b1, 0, i < 3, st);
            tot_st += st;
        end
        check("t2_no_bubble", tot_st, 0);
        drain();

        // Backpressure: two 1-beat vectors with out_ready low.
        ready_fixed = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        run_vector(1, 1'b1, 16'h4000, 1'b1, 0, 1'b1, st);
        run_vector(1, 1'b0, NO'($urandom), 1'b1, 0, 1'b0, st);
        @(negedge clk);
        check("t3_ready_low", in_ready, 0);
        check("t3_out_valid", out_valid, 1);
        cap_a   = pdpu_a;
        cap_acc = pdpu_acc;
        repeat (3) @(negedge clk);
        check("t3_pdpu_a_stable", pdpu_a, cap_a);
        check("t3_pdpu_acc_stable", pdpu_acc, cap_acc);
        check("t3_ready_still_low", in_ready, 0);
        ready_fixed = 1'b1;
        drain();

        // Flush after first of 3 beats; the next vector must start clean.
        send_beat(N*NI'($urandom), N*NI'($urandom), 1'b0, NO'($urandom), st);
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        check("t4_flush_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        run_vector(2, 1'b1, 16'h0000, 1'b1, 0, 1'b0, st);
        drain();

        // Flush while a last beat sits in the op stage: its result is dropped.
        send_beat(N*NI'($urandom), N*NI'($urandom), 1'b1, NO'($urandom), st);
        in_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        run_vector(1, 1'b1, 16'h0000, 1'b1, 0, 1'b0, st);
        drain();

        // Asynchronous reset mid-vector at a random phase.
        send_beat(N*NI'($urandom), N*NI'($urandom), 1'b0, NO'($urandom), st);
        #($urandom_range(1, 7));
        rst = 1'b1;
        #1;
        check("t5_in_ready", in_ready, 0);
        check("t5_out_valid", out_valid, 0);
        check("t5_out_result", out_result, 0);
        check("t5_out_beats", out_beats, 0);
        check("t5_pdpu_a", pdpu_a, 0);
        check("t5_pdpu_b", pdpu_b, 0);
        check("t5_pdpu_acc", pdpu_acc, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_vector(3, 1'b0, NO'($urandom), 1'b1, 0, 1'b0, st);
        drain();

        // Randomised stream: random lengths, data, input gaps and output backpressure.
        ready_rand = 1'b1;
        for (int v = 0; v < 40; v++) begin
            run_vector($urandom_range(1, 5), 1'b0, NO'($urandom), 1'b1, 2,
                       $urandom_range(0, 1) == 1, st);
        end
        in_valid = 1'b0;
        ready_rand = 1'b0;
        ready_fixed = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
